// File: rtl/ktc32_pkg.sv
// Shared types and constants for the KTC32 multi-cycle core.
package ktc32_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned NREGS   = 32;
    localparam int unsigned OP_MSB  = 31;
    localparam int unsigned OP_LSB  = 26;
    localparam int unsigned RD_MSB  = 25;
    localparam int unsigned RD_LSB  = 21;
    localparam int unsigned RS1_MSB = 20;
    localparam int unsigned RS1_LSB = 16;
    localparam int unsigned RS2_MSB = 15;
    localparam int unsigned RS2_LSB = 11;
    localparam int unsigned IMM_MSB = 15;
    localparam int unsigned JOFF_MSB = 20;

    localparam logic [XLEN-1:0] LED_ADDR = 32'h8000_0000;

    typedef enum logic [5:0] {
        OP_ADD  = 6'h00,
        OP_SUB  = 6'h01,
        OP_AND  = 6'h02,
        OP_OR   = 6'h03,
        OP_XOR  = 6'h04,
        OP_SLT  = 6'h05,
        OP_ADDI = 6'h08,
        OP_LUI  = 6'h09,
        OP_ORI  = 6'h0A,
        OP_LW   = 6'h10,
        OP_SW   = 6'h11,
        OP_BEQ  = 6'h18,
        OP_BNE  = 6'h19,
        OP_JAL  = 6'h1C,
        OP_JALR = 6'h1D
    } opcode_e;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        MEM    = 2'd3
    } state_e;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } mem_req_t;

    function automatic logic [XLEN-1:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/ktc32_mem_if.sv
// Single-port memory bus between the core (master) and the unified RAM (slave).
interface ktc32_mem_if;
    import ktc32_pkg::*;

    mem_req_t        req;
    logic [XLEN-1:0] rdata;

    modport master (output req, input rdata);
    modport slave  (input req, output rdata);
endinterface

// File: rtl/ktc32_ram.sv
// Unified instruction/data RAM: synchronous write, synchronous read, word addressed.
module ktc32_ram
    import ktc32_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter string       PROG_FILE = ""
) (
    input  logic         clk,
    ktc32_mem_if.slave   bus
);

    localparam int unsigned AW = $clog2(MEM_WORDS);

    logic [XLEN-1:0] mem [0:MEM_WORDS-1];
    logic [AW-1:0]   idx;

    // Image preload happens externally through mem; the name is kept for the board flow.
    if (PROG_FILE != "") begin : g_prog_file
    end

    assign idx = bus.req.addr[AW+1:2];

    // Upper address bits wrap and byte offset is ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.req.addr[XLEN-1:AW+2], bus.req.addr[1:0]};

    always_ff @(posedge clk) begin
        if (bus.req.we) begin
            mem[idx] <= bus.req.wdata;
        end
        bus.rdata <= mem[idx];
    end

endmodule

// File: rtl/ktc32_arty_top.sv
// KTC32 Arty S7 top: multi-cycle 32-bit core, unified RAM and a memory-mapped 4-bit LED port.
module ktc32_arty_top
    import ktc32_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter string       PROG_FILE = ""
) (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] led
);

    ktc32_mem_if bus ();

    ktc32_ram #(
        .MEM_WORDS (MEM_WORDS),
        .PROG_FILE (PROG_FILE)
    ) ram (
        .clk (clk),
        .bus (bus)
    );

    state_e          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic [XLEN-1:0] opd;
    logic            ld_led;
    logic [XLEN-1:0] regs [0:NREGS-1];

    opcode_e         op;
    logic [4:0]      rd;
    logic [XLEN-1:0] simm;
    logic [XLEN-1:0] joff;
    logic [XLEN-1:0] ea;
    logic [XLEN-1:0] pc4;
    logic            ea_is_led;

    assign op        = opcode_e'(ir[OP_MSB:OP_LSB]);
    assign rd        = ir[RD_MSB:RD_LSB];
    assign simm      = sext16(ir[IMM_MSB:0]);
    assign joff      = {{11{ir[JOFF_MSB]}}, ir[JOFF_MSB:0]};
    assign ea        = opa + simm;
    assign pc4       = pc + 32'd4;
    assign ea_is_led = (ea == LED_ADDR);

    logic            wb_en_c;
    logic [XLEN-1:0] wb_val_c;
    logic [XLEN-1:0] next_pc_c;

    // EXEC-stage ALU, write-back value and next pc.
    always_comb begin
        wb_en_c   = 1'b0;
        wb_val_c  = '0;
        next_pc_c = pc4;
        case (op)
            OP_ADD:  begin wb_en_c = 1'b1; wb_val_c = opa + opb; end
            OP_SUB:  begin wb_en_c = 1'b1; wb_val_c = opa - opb; end
            OP_AND:  begin wb_en_c = 1'b1; wb_val_c = opa & opb; end
            OP_OR:   begin wb_en_c = 1'b1; wb_val_c = opa | opb; end
            OP_XOR:  begin wb_en_c = 1'b1; wb_val_c = opa ^ opb; end
            OP_SLT:  begin wb_en_c = 1'b1; wb_val_c = {31'b0, $signed(opa) < $signed(opb)}; end
            OP_ADDI: begin wb_en_c = 1'b1; wb_val_c = ea; end
            OP_LUI:  begin wb_en_c = 1'b1; wb_val_c = {ir[IMM_MSB:0], 16'h0000}; end
            OP_ORI:  begin wb_en_c = 1'b1; wb_val_c = opa | {16'h0000, ir[IMM_MSB:0]}; end
            OP_BEQ:  if (opd == opa) next_pc_c = pc4 + {simm[XLEN-3:0], 2'b00};
            OP_BNE:  if (opd != opa) next_pc_c = pc4 + {simm[XLEN-3:0], 2'b00};
            OP_JAL:  begin
                wb_en_c   = 1'b1;
                wb_val_c  = pc4;
                next_pc_c = pc4 + {joff[XLEN-3:0], 2'b00};
            end
            OP_JALR: begin
                wb_en_c   = 1'b1;
                wb_val_c  = pc4;
                next_pc_c = {ea[XLEN-1:2], 2'b00};
            end
            default: ;
        endcase
    end

    // RAM request: instruction fetch in FETCH, data access in EXEC.
    always_comb begin
        bus.req = '0;
        case (state)
            FETCH: bus.req.addr = pc;
            EXEC: begin
                bus.req.addr  = ea;
                bus.req.wdata = opd;
                bus.req.we    = (op == OP_SW) && !ea_is_led;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= FETCH;
            pc     <= '0;
            ir     <= '0;
            opa    <= '0;
            opb    <= '0;
            opd    <= '0;
            ld_led <= 1'b0;
            led    <= 4'h0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                FETCH: state <= DECODE;
                DECODE: begin
                    ir    <= bus.rdata;
                    opa   <= regs[bus.rdata[RS1_MSB:RS1_LSB]];
                    opb   <= regs[bus.rdata[RS2_MSB:RS2_LSB]];
                    opd   <= regs[bus.rdata[RD_MSB:RD_LSB]];
                    state <= EXEC;
                end
                EXEC: begin
                    if (op == OP_LW) begin
                        ld_led <= ea_is_led;
                        state  <= MEM;
                    end else begin
                        if (wb_en_c && (rd != 5'd0)) begin
                            regs[rd] <= wb_val_c;
                        end
                        if ((op == OP_SW) && ea_is_led) begin
                            led <= opd[3:0];
                        end
                        pc    <= next_pc_c;
                        state <= FETCH;
                    end
                end
                MEM: begin
                    if (rd != 5'd0) begin
                        regs[rd] <= ld_led ? {28'h0, led} : bus.rdata;
                    end
                    pc    <= pc4;
                    state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_ktc32_arty_top.sv
// Bench for ktc32_arty_top: instruction-level reference model, directed programs and random programs.
module tb_ktc32_arty_top;
    import ktc32_pkg::*;

    localparam int unsigned MW = 1024;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] led;

    ktc32_arty_top #(.MEM_WORDS(MW), .PROG_FILE("")) dut (
        .clk   (clk),
        .reset (reset),
        .led   (led)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mmem [0:MW-1];
    logic [31:0] mreg [0:31];
    logic [31:0] mpc;
    logic [3:0]  mled;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
        return {op, rd, rs1, rs2, 11'h000};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [15:0] imm);
        return {op, rd, rs1, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [4:0] rd,
                                          input logic [20:0] off);
        return {op, rd, off};
    endfunction

    task automatic mwr(input logic [4:0] rd, input logic [31:0] v);
        if (rd != 5'd0) mreg[rd] = v;
    endtask

    // Architectural semantics of one instruction; returns its cycle count.
    task automatic model_step(output int cyc);
        logic [31:0] ir, a, b, d, simm, ea, npc, joff;
        logic [4:0]  rd;
        ir   = mmem[mpc[11:2]];
        rd   = ir[25:21];
        a    = mreg[ir[20:16]];
        b    = mreg[ir[15:11]];
        d    = mreg[rd];
        simm = {{16{ir[15]}}, ir[15:0]};
        joff = {{11{ir[20]}}, ir[20:0]};
        ea   = a + simm;
        npc  = mpc + 32'd4;
        cyc  = 3;
        case (ir[31:26])
            6'h00: mwr(rd, a + b);
            6'h01: mwr(rd, a - b);
            6'h02: mwr(rd, a & b);
            6'h03: mwr(rd, a | b);
            6'h04: mwr(rd, a ^ b);
            6'h05: mwr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
            6'h08: mwr(rd, a + simm);
            6'h09: mwr(rd, {ir[15:0], 16'h0000});
            6'h0A: mwr(rd, a | {16'h0000, ir[15:0]});
            6'h10: begin
                cyc = 4;
                mwr(rd, (ea == 32'h8000_0000) ? {28'h0, mled} : mmem[ea[11:2]]);
            end
            6'h11: begin
                if (ea == 32'h8000_0000) mled = d[3:0];
                else mmem[ea[11:2]] = d;
            end
            6'h18: if (d == a) npc = mpc + 32'd4 + (simm << 2);
            6'h19: if (d != a) npc = mpc + 32'd4 + (simm << 2);
            6'h1C: begin mwr(rd, mpc + 32'd4); npc = mpc + 32'd4 + (joff << 2); end
            6'h1D: begin mwr(rd, mpc + 32'd4); npc = (a + simm) & ~32'd3; end
            default: ;
        endcase
        mpc = npc;
    endtask

    // Advance DUT and model by one instruction, comparing every cycle.
    task automatic run_instr(output int cyc);
        logic [3:0]  old_led;
        logic [31:0] old_pc, instr;
        old_led = mled;
        old_pc  = mpc;
        instr   = mmem[mpc[11:2]];
        model_step(cyc);
        for (int k = 1; k <= cyc; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) check("ir", dut.ir, instr);
            check("led", {28'h0, led}, {28'h0, (k == cyc) ? mled : old_led});
            check("pc", dut.pc, (k == cyc) ? mpc : old_pc);
        end
        for (int r = 0; r < 32; r++) begin
            check($sformatf("x%0d", r), dut.regs[r], mreg[r]);
        end
    endtask

    task automatic run_to(input logic [31:0] end_pc, input int max_steps, output int steps);
        int cyc;
        steps = 0;
        while (mpc < end_pc && steps < max_steps) begin
            run_instr(cyc);
            steps++;
        end
    endtask

    task automatic start_reset();
        @(negedge clk);
        reset = 1'b0;
        mpc  = '0;
        mled = '0;
        for (int r = 0; r < 32; r++) mreg[r] = '0;
        for (int i = 0; i < MW; i++) begin
            mmem[i] = '0;
            dut.ram.mem[i] = '0;
        end
    endtask

    task automatic finish_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst led", {28'h0, led}, 32'h0);
        check("rst pc", dut.pc, 32'h0);
        check("rst state", 32'(dut.state), 32'(FETCH));
    endtask

    task automatic load(input int addr_w, input logic [31:0] w);
        mmem[addr_w] = w;
        dut.ram.mem[addr_w] = w;
    endtask

    task automatic gen_random(input int i, output logic [31:0] w);
        int unsigned r;
        logic [4:0] rd, rs1, rs2;
        r   = $urandom_range(0, 99);
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        if (r < 30)      w = enc_r(6'($urandom_range(0, 5)), rd, rs1, rs2);
        else if (r < 40) w = enc_i(6'h08, rd, rs1, 16'($urandom));
        else if (r < 45) w = enc_i(6'h09, rd, rs1, 16'($urandom));
        else if (r < 50) w = enc_i(6'h0A, rd, rs1, 16'($urandom));
        else if (r < 57) w = enc_i(6'h11, rd, 5'd0, 16'(32'h800 + 4 * $urandom_range(0, 255)));
        else if (r < 64) w = enc_i(6'h10, rd, 5'd0, 16'(32'h800 + 4 * $urandom_range(0, 255)));
        else if (r < 69) w = enc_i(6'h11, rd, 5'd8, 16'h0000);
        else if (r < 72) w = enc_i(6'h10, rd, 5'd8, 16'h0000);
        else if (r < 82) w = enc_i(($urandom_range(0, 1) != 0) ? 6'h18 : 6'h19, rd, rs1,
                                   16'($urandom_range(0, 3)));
        else if (r < 87) w = enc_j(6'h1C, rd, 21'($urandom_range(0, 3)));
        else if (r < 92) w = enc_i(6'h1D, rd, 5'd0,
                                   16'(4 * (i + 1 + $urandom_range(0, 3)) + $urandom_range(0, 3)));
        else begin
            logic [5:0] nops [6];
            nops = '{6'h06, 6'h07, 6'h0B, 6'h12, 6'h1F, 6'h3F};
            w = enc_r(nops[$urandom_range(0, 5)], rd, rs1, rs2);
        end
    endtask

    initial begin
        int steps, cyc, loops;
        logic [31:0] w;
        reset = 1'b1;

        // Sum to LED: 5 + 3 = 8
        start_reset();
        load(0, enc_i(6'h08, 5'd1, 5'd0, 16'd5));
        load(1, enc_i(6'h08, 5'd2, 5'd0, 16'd3));
        load(2, enc_r(6'h00, 5'd3, 5'd1, 5'd2));
        load(3, enc_i(6'h09, 5'd7, 5'd0, 16'h8000));
        load(4, enc_i(6'h11, 5'd3, 5'd7, 16'h0000));
        finish_reset();
        run_to(32'd20, 10, steps);
        check("t1 led", {28'h0, led}, 32'h8);
        check("t1 x3", dut.regs[3], 32'd8);

        // Store/load round trip through RAM word 0x40, then to LED
        start_reset();
        load(0, enc_i(6'h08, 5'd1, 5'd0, 16'd5));
        load(1, enc_i(6'h11, 5'd1, 5'd0, 16'h0100));
        load(2, enc_i(6'h10, 5'd4, 5'd0, 16'h0100));
        load(3, enc_i(6'h09, 5'd7, 5'd0, 16'h8000));
        load(4, enc_i(6'h11, 5'd4, 5'd7, 16'h0000));
        load(5, enc_i(6'h10, 5'd9, 5'd7, 16'h0000));
        finish_reset();
        run_instr(cyc);
        run_instr(cyc);
        run_instr(cyc);
        check("t2 lw cycles", 32'(cyc), 32'd4);
        run_to(32'd24, 10, steps);
        check("t2 led", {28'h0, led}, 32'h5);
        check("t2 ram[0x40]", dut.ram.mem[32'h40], 32'd5);
        check("t2 x4", dut.regs[4], 32'd5);
        check("t2 led readback x9", dut.regs[9], 32'd5);

        // Countdown loop
        start_reset();
        load(0, enc_i(6'h08, 5'd1, 5'd0, 16'd3));
        load(1, enc_i(6'h08, 5'd2, 5'd0, 16'd1));
        load(2, enc_r(6'h01, 5'd1, 5'd1, 5'd2));
        load(3, enc_i(6'h19, 5'd1, 5'd0, 16'hFFFE));
        load(4, enc_i(6'h09, 5'd7, 5'd0, 16'h8000));
        load(5, enc_i(6'h11, 5'd1, 5'd7, 16'h0000));
        finish_reset();
        loops = 0;
        steps = 0;
        while (mpc < 32'd24 && steps < 30) begin
            if (mpc == 32'd8) loops++;
            run_instr(cyc);
            steps++;
        end
        check("t3 loop count", 32'(loops), 32'd3);
        check("t3 led", {28'h0, led}, 32'h0);
        check("t3 x1", dut.regs[1], 32'd0);

        // JAL / JALR round trip, x0 writes discarded
        start_reset();
        load(0, enc_j(6'h1C, 5'd31, 21'd2));
        load(1, enc_i(6'h08, 5'd5, 5'd0, 16'd7));
        load(2, enc_j(6'h1C, 5'd0, 21'd2));
        load(3, enc_i(6'h08, 5'd6, 5'd0, 16'd9));
        load(4, enc_i(6'h1D, 5'd0, 5'd31, 16'd0));
        finish_reset();
        run_to(32'd20, 10, steps);
        check("t4 steps", 32'(steps), 32'd5);
        check("t4 x31", dut.regs[31], 32'd4);
        check("t4 x5", dut.regs[5], 32'd7);
        check("t4 x6", dut.regs[6], 32'd9);
        check("t4 x0", dut.regs[0], 32'd0);
        check("t4 pc", dut.pc, 32'd20);

        // Reset during EXEC of an LED store of 0xF
        start_reset();
        load(0, enc_i(6'h08, 5'd1, 5'd0, 16'd15));
        load(1, enc_i(6'h09, 5'd7, 5'd0, 16'h8000));
        load(2, enc_i(6'h11, 5'd1, 5'd7, 16'h0000));
        finish_reset();
        run_instr(cyc);
        run_instr(cyc);
        repeat (2) @(posedge clk);
        #1;
        check("t5 in exec", 32'(dut.state), 32'(EXEC));
        reset = 1'b0;
        #1;
        check("t5 led", {28'h0, led}, 32'h0);
        check("t5 pc", dut.pc, 32'h0);
        check("t5 x1", dut.regs[1], 32'h0);
        @(posedge clk);
        #1;
        check("t5 led held", {28'h0, led}, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Random forward-flowing programs
        for (int t = 0; t < 6; t++) begin
            start_reset();
            load(0, enc_i(6'h09, 5'd8, 5'd0, 16'h8000));
            for (int i = 1; i < 120; i++) begin
                gen_random(i, w);
                load(i, w);
            end
            finish_reset();
            run_to(32'd480, 400, steps);
            check("rand end reached", 32'(mpc >= 32'd480), 32'd1);
            for (int i = 0; i < MW; i++) begin
                check($sformatf("mem[%0d]", i), dut.ram.mem[i], mmem[i]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
